synapse_event_sched: RTL and testbench
======================================

Name: synapse_event_sched

Overview:
- Schedules presynaptic spike events from p_nsrc sources onto one shared synapse_w instance, so up to eight synapses time-share one integrator.
- Holds a per-source weight register file and keeps one pending flag per source.
- Arbitrates pending flags round-robin, then issues a one-cycle event plus weight to the synapse.
- Waits for the synapse's sync pulse, or a timeout, before issuing the next event.

Parameters:
p_nsrc, 8, number of presynaptic spike sources
p_width, 8, weight width; must match synapse_w p_width
p_gap, 4, minimum idle cycles between the end of one event and the next issue (>=1)
p_timeout, 64, cycles to wait for i_syn_sync before abandoning an event (>=2)

Ports:
i_base_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_spike  in  p_nsrc  synchronous spike pulses; bit k high for one cycle = one event from source k
i_wr_en  in  1  weight write strobe
i_wr_addr  in  clog2(p_nsrc)  weight register index
i_wr_data  in  p_width  weight value
i_syn_sync  in  1  synapse_w o_sync: one-cycle pulse when the issued event has been integrated
o_event  out  1  one-cycle event pulse to synapse_w i_event
o_weight  out  p_width  weight to synapse_w i_weight; stable from the issue cycle until the next issue
o_src  out  clog2(p_nsrc)  index of the source last issued
o_busy  out  1  high in ISSUE and WAIT
o_drop  out  1  one-cycle pulse when a spike hits an already-pending source
o_timeout  out  1  one-cycle pulse when WAIT expires without sync

Behaviour:
- Reset (asynchronous, immediate):
  - all outputs 0
  - pending flags 0, weight registers 0, RR pointer 0, state IDLE
  - reset during WAIT discards the in-flight event with no pulse on any output
- Pending flags:
  - i_spike[k]=1 sets pend[k]
  - if pend[k] is already set and is not being granted this cycle, the spike is dropped and o_drop pulses next cycle; multiple drops in one cycle give a single pulse
  - the granted bit is cleared in the ISSUE cycle; a same-cycle spike on the granted source re-sets it (set wins, no drop)
- FSM:
  - IDLE: when any pend bit is set, grant the first set bit at or after the RR pointer (wrap-around) -> ISSUE
  - ISSUE (1 cycle):
    - o_event=1; o_weight=wreg[grant]; o_src=grant
    - clear pend[grant]; pointer=grant+1 mod p_nsrc
    - -> WAIT, timer=0
  - WAIT: i_syn_sync=1 -> GAP; timer reaches p_timeout-1 without sync -> o_timeout pulse, -> GAP
  - GAP: count p_gap cycles -> IDLE
- Event rate and latency:
  - minimum event period = 1 + (sync latency) + p_gap cycles
  - spike-to-o_event latency from IDLE is 1 cycle: spike in cycle n, pend set at the edge, o_event in cycle n+1
- Sync handling: i_syn_sync outside WAIT is ignored, including in the ISSUE cycle.
- Weight writes:
  - take effect at the clock edge
  - a write to the granted index in the ISSUE cycle does not alter the issued o_weight (old value); the new value applies to later events
  - writes with i_wr_addr >= p_nsrc are ignored
- Widths: the timer is clog2(p_timeout) bits and the gap counter clog2(p_gap+1) bits; neither wraps, both saturate at their terminal count.

Decomposition:
- Package syn_sched_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, GAP)
  - the clog2-derived index width
  - default constants
- Sub-module rr_arbiter (p_nsrc): combinational one-hot grant plus index from a request vector and pointer. It is reused by the future neuron-side schedulers.

Test Plan:
- Reset, write wreg[3]=0xFE, pulse i_spike=0x08 -> o_event one cycle later, o_weight=0xFE, o_src=3; sync after 10 cycles -> o_busy low, next issue allowed no earlier than 4 cycles later.
- i_spike=0x81 in one cycle with pointer 0 -> issue src 0 then src 7, each with its own weight, 2 events total, no drop.
- Spike src 2 twice while it is pending (second spike during WAIT for src 5) -> exactly one o_drop pulse, src 2 issued once.
- Never assert sync -> o_timeout pulses 64 cycles after the issue, FSM returns to IDLE after the gap, and the next pending source issues.
- Write wreg[1]=0x7F in the same cycle src 1 issues with old value 0x10 -> o_weight=0x10; next src-1 event -> 0x7F.
- Assert i_rst_n=0 mid-WAIT -> all outputs 0 immediately, pend cleared; after release, an issue occurs only on new spikes.

Source files
------------

// File: rtl/syn_sched_pkg.sv
// Shared types and defaults for the synapse event scheduler.
// Holds the FSM state enum, index-width helper and default sizes.
package syn_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP
  } state_t;

  localparam int NSRC_DEF    = 8;
  localparam int WIDTH_DEF   = 8;
  localparam int GAP_DEF     = 4;
  localparam int TIMEOUT_DEF = 64;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_w(NSRC_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr.
// Ports: req, ptr in; one-hot gnt, its index idx and valid out.
module rr_arbiter
  import syn_sched_pkg::*;
#(
  parameter int p_nsrc = NSRC_DEF,
  localparam int IW = idx_w(p_nsrc)
) (
  input  logic [p_nsrc-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [p_nsrc-1:0] gnt,
  output logic [IW-1:0]     idx,
  output logic              valid
);

  int j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = 0; i < p_nsrc; i++) begin
      j = int'(ptr) + i;
      if (j >= p_nsrc) j = j - p_nsrc;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/synapse_event_sched.sv
// Time-shares one synapse integrator between p_nsrc spike sources.
// Ports: spikes/weight writes/sync in; event, weight, src, busy, drop, timeout out.
module synapse_event_sched
  import syn_sched_pkg::*;
#(
  parameter int p_nsrc    = NSRC_DEF,
  parameter int p_width   = WIDTH_DEF,
  parameter int p_gap     = GAP_DEF,
  parameter int p_timeout = TIMEOUT_DEF,
  localparam int IW = idx_w(p_nsrc)
) (
  input  logic               i_base_clk,
  input  logic               i_rst_n,
  input  logic [p_nsrc-1:0]  i_spike,
  input  logic               i_wr_en,
  input  logic [IW-1:0]      i_wr_addr,
  input  logic [p_width-1:0] i_wr_data,
  input  logic               i_syn_sync,
  output logic               o_event,
  output logic [p_width-1:0] o_weight,
  output logic [IW-1:0]      o_src,
  output logic               o_busy,
  output logic               o_drop,
  output logic               o_timeout
);

  localparam int TW = $clog2(p_timeout);
  localparam int GW = $clog2(p_gap + 1);
  localparam logic [TW-1:0] TMAX = TW'(p_timeout - 1);
  localparam logic [GW-1:0] GMAX = GW'(p_gap);

  state_t state, nstate;

  logic [p_nsrc-1:0]  pend;
  logic [p_width-1:0] wreg [p_nsrc];
  logic [IW-1:0]      ptr;
  logic [TW-1:0]      timer;
  logic [GW-1:0]      gcnt;
  logic [p_nsrc-1:0]  gnt_q;
  logic [p_width-1:0] weight_q;
  logic [IW-1:0]      src_q;
  logic               drop_q;

  logic [p_nsrc-1:0]  req;
  logic [p_nsrc-1:0]  gnt;
  logic [IW-1:0]      gidx;
  logic               gvalid;
  logic [p_nsrc-1:0]  clr;
  logic [p_width-1:0] wsel;
  logic               wr_ok;
  logic               gap_done;
  logic               tmo_hit;
  logic               go;

  // A spike arriving while idle is visible to the arbiter
  // in the same cycle, giving one-cycle spike-to-event latency.
  assign req = pend | i_spike;

  rr_arbiter #(.p_nsrc(p_nsrc)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .gnt   (gnt),
    .idx   (gidx),
    .valid (gvalid)
  );

  assign wr_ok    = i_wr_en && (int'(i_wr_addr) < p_nsrc);
  assign gap_done = (state == S_GAP) && (gcnt == GMAX);
  assign tmo_hit  = (timer == TMAX);
  assign go       = ((state == S_IDLE) || gap_done) && gvalid;
  assign clr      = (state == S_ISSUE) ? gnt_q : '0;

  // Forward a same-cycle write so the issued weight reflects
  // every write made before the issue cycle.
  assign wsel = (wr_ok && (i_wr_addr == gidx)) ? i_wr_data
                                               : wreg[gidx];

  always_ff @(posedge i_base_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:  if (go) nstate = S_ISSUE;
      S_ISSUE: nstate = S_WAIT;
      S_WAIT:  if (i_syn_sync || tmo_hit) nstate = S_GAP;
      S_GAP: begin
        if (gap_done) nstate = go ? S_ISSUE : S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    o_event   = (state == S_ISSUE);
    o_busy    = (state == S_ISSUE) || (state == S_WAIT);
    o_timeout = (state == S_WAIT) && !i_syn_sync && tmo_hit;
  end

  assign o_weight = weight_q;
  assign o_src    = src_q;
  assign o_drop   = drop_q;

  always_ff @(posedge i_base_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend   <= '0;
      drop_q <= 1'b0;
    end else begin
      // set wins over the issue-cycle clear
      pend   <= (pend & ~clr) | i_spike;
      drop_q <= |(i_spike & pend & ~clr);
    end
  end

  always_ff @(posedge i_base_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < p_nsrc; k++) wreg[k] <= '0;
    end else if (wr_ok) begin
      wreg[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_base_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gnt_q    <= '0;
      src_q    <= '0;
      weight_q <= '0;
      ptr      <= '0;
    end else begin
      if (go) begin
        gnt_q    <= gnt;
        src_q    <= gidx;
        weight_q <= wsel;
      end
      if (state == S_ISSUE) begin
        ptr <= (src_q == IW'(p_nsrc - 1)) ? '0
                                          : src_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_base_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timer <= '0;
      gcnt  <= '0;
    end else begin
      if (state == S_ISSUE)
        timer <= '0;
      else if ((state == S_WAIT) && !tmo_hit)
        timer <= timer + 1'b1;
      // gcnt counts GAP cycles 1..p_gap
      if (state != S_GAP)
        gcnt <= GW'(1);
      else if (gcnt != GMAX)
        gcnt <= gcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_synapse_event_sched.sv
// Self-checking bench for synapse_event_sched.
// Time-based scheduling model plus directed literal checks.
module tb_synapse_event_sched;

  localparam int N   = 8;
  localparam int W   = 8;
  localparam int GAP = 4;
  localparam int TO  = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] spike;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic         sync;
  logic         o_event;
  logic [W-1:0] o_weight;
  logic [2:0]   o_src;
  logic         o_busy;
  logic         o_drop;
  logic         o_timeout;

  always #5 clk = ~clk;

  synapse_event_sched dut (
    .i_base_clk (clk),
    .i_rst_n    (rst_n),
    .i_spike    (spike),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_syn_sync (sync),
    .o_event    (o_event),
    .o_weight   (o_weight),
    .o_src      (o_src),
    .o_busy     (o_busy),
    .o_drop     (o_drop),
    .o_timeout  (o_timeout)
  );

  int checks = 0;
  int fails  = 0;
  int n_ev   = 0;
  int n_drop = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_pend;
  logic [W-1:0] m_w [N];
  logic [W-1:0] m_wv;
  int           m_ptr, m_iss, m_end, m_src, t;
  bit           m_ev, m_wait, m_drop;
  logic [N-1:0] req, clr;
  bit           e_tmo, nd, go;

  function automatic int first_from(input logic [N-1:0] r,
                                    input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    for (int k = 0; k < N; k++) m_w[k] = '0;
    m_wv   = '0;
    m_ptr  = 0;
    m_iss  = 0;
    m_end  = -1000;
    m_src  = 0;
    m_ev   = 0;
    m_wait = 0;
    m_drop = 0;
  endtask

  initial begin
    t = 0;
    model_reset();
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        model_reset();
        chk("rst_event",   o_event,   0);
        chk("rst_busy",    o_busy,    0);
        chk("rst_timeout", o_timeout, 0);
        chk("rst_drop",    o_drop,    0);
        chk("rst_src",     o_src,     0);
        chk("rst_weight",  o_weight,  0);
      end else begin
        e_tmo = m_wait && !sync && (t - m_iss == TO);
        chk("event",   o_event,   m_ev);
        chk("src",     o_src,     m_src);
        chk("weight",  o_weight,  m_wv);
        chk("busy",    o_busy,    m_ev || m_wait);
        chk("timeout", o_timeout, e_tmo);
        chk("drop",    o_drop,    m_drop);
        if (o_event) n_ev++;
        if (o_drop)  n_drop++;
        // advance to the next cycle
        req = m_pend | spike;
        clr = '0;
        if (m_ev) clr[m_src] = 1'b1;
        nd = |(spike & m_pend & ~clr);
        go = !m_ev && !m_wait && (t - m_end >= GAP)
             && (req != '0);
        if (wr_en && int'(wr_addr) < N) m_w[wr_addr] = wr_data;
        if (m_ev) m_ptr = (m_src + 1) % N;
        if (m_ev) m_wait = 1;
        else if (m_wait && (sync || e_tmo)) begin
          m_wait = 0;
          m_end  = t;
        end
        m_pend = (m_pend & ~clr) | spike;
        m_drop = nd;
        if (go) begin
          m_src = first_from(req, m_ptr);
          m_wv  = m_w[m_src];
          m_iss = t + 1;
        end
        m_ev = go;
      end
      t++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    spike = '0;
    sync  = 1'b0;
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic pulse_spike(input logic [N-1:0] v);
    @(negedge clk);
    spike = v;
    @(negedge clk);
    spike = '0;
  endtask

  // starts at a negedge; returns 3 ns into the event cycle
  task automatic wait_event(input int max);
    for (int i = 0; i < max; i++) begin
      #3;
      if (o_event) break;
      @(negedge clk);
    end
    chk("event_seen", o_event, 1);
  endtask

  task automatic do_sync(input int lat);
    repeat (lat) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  int k;

  initial begin
    rst_n   = 1'b0;
    spike   = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    sync    = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("init_event", o_event, 0);
    chk("init_busy",  o_busy,  0);

    // 1: basic issue, latency and gap
    do_reset();
    wr(3, 8'hFE);
    pulse_spike(8'h08);
    #3;
    chk("t1_event",  o_event,  1);
    chk("t1_weight", o_weight, 8'hFE);
    chk("t1_src",    o_src,    3);
    chk("t1_busy",   o_busy,   1);
    @(negedge clk);
    spike = 8'h01;
    @(negedge clk);
    spike = '0;
    repeat (8) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    #3;
    chk("t1_busy_low", o_busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #3;
      chk("t1_gap_quiet", o_event, 0);
    end
    @(negedge clk);
    #3;
    chk("t1_next_event", o_event, 1);
    chk("t1_next_src",   o_src,   0);
    do_sync(2);

    // 2: two sources in one cycle
    do_reset();
    wr(0, 8'h11);
    wr(7, 8'h77);
    n_ev   = 0;
    n_drop = 0;
    pulse_spike(8'h81);
    wait_event(10);
    chk("t2_src_a", o_src,    0);
    chk("t2_w_a",   o_weight, 8'h11);
    do_sync(3);
    wait_event(20);
    chk("t2_src_b", o_src,    7);
    chk("t2_w_b",   o_weight, 8'h77);
    do_sync(3);
    repeat (10) @(negedge clk);
    #3;
    chk("t2_events", n_ev,   2);
    chk("t2_drops",  n_drop, 0);

    // 3: drop on already-pending source
    do_reset();
    wr(5, 8'h55);
    wr(2, 8'h22);
    n_ev   = 0;
    n_drop = 0;
    pulse_spike(8'h20);
    wait_event(10);
    chk("t3_src_a", o_src, 5);
    pulse_spike(8'h04);
    pulse_spike(8'h04);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    wait_event(20);
    chk("t3_src_b", o_src,    2);
    chk("t3_w_b",   o_weight, 8'h22);
    do_sync(2);
    repeat (10) @(negedge clk);
    #3;
    chk("t3_events", n_ev,   2);
    chk("t3_drops",  n_drop, 1);

    // 4: timeout without sync
    do_reset();
    wr(4, 8'h44);
    wr(6, 8'h66);
    pulse_spike(8'h50);
    wait_event(10);
    chk("t4_src_a", o_src, 4);
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      #3;
      if (o_timeout) begin
        k = i;
        break;
      end
    end
    chk("t4_tmo_delay", k, 64);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      #3;
      if (o_event) begin
        k = i;
        break;
      end
    end
    chk("t4_next_delay", k, 5);
    chk("t4_src_b", o_src,    6);
    chk("t4_w_b",   o_weight, 8'h66);
    do_sync(1);

    // 5: write during the issue cycle
    do_reset();
    wr(1, 8'h10);
    @(negedge clk);
    spike = 8'h02;
    @(negedge clk);
    spike   = '0;
    wr_en   = 1'b1;
    wr_addr = 3'd1;
    wr_data = 8'h7F;
    #3;
    chk("t5_event",  o_event,  1);
    chk("t5_w_old",  o_weight, 8'h10);
    @(negedge clk);
    wr_en = 1'b0;
    sync  = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    #3;
    chk("t5_w_hold", o_weight, 8'h10);
    pulse_spike(8'h02);
    wait_event(20);
    chk("t5_src",   o_src,    1);
    chk("t5_w_new", o_weight, 8'h7F);
    do_sync(1);

    // 6: reset in the middle of WAIT
    do_reset();
    wr(2, 8'h33);
    pulse_spike(8'h0C);
    wait_event(10);
    chk("t6_src", o_src, 2);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_event",   o_event,   0);
    chk("t6_busy",    o_busy,    0);
    chk("t6_weight",  o_weight,  0);
    chk("t6_src0",    o_src,     0);
    chk("t6_timeout", o_timeout, 0);
    chk("t6_drop",    o_drop,    0);
    @(negedge clk);
    rst_n = 1'b1;
    n_ev  = 0;
    repeat (20) @(negedge clk);
    #3;
    chk("t6_no_event", n_ev, 0);
    pulse_spike(8'h08);
    wait_event(10);
    chk("t6_src_new", o_src,    3);
    chk("t6_w_new",   o_weight, 0);
    do_sync(1);
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
